// File: rtl/key_arb_pkg.sv
// Shared types and width helpers for the key register arbiter.
package key_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int N_REQ_DEF    = 4;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_HOLD_DEF = 16;

    // Index width for n items, never narrower than one bit
    function automatic int width_of(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    localparam int ID_W_DEF   = width_of(N_REQ_DEF);
    localparam int HOLD_W_DEF = width_of(MAX_HOLD_DEF);

endpackage

// File: rtl/key_reg_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above ptr, with wrap.
module rr_pick
    import key_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    // Priority scan starting at ptr; wrap by compare so N_REQ need not be a power of two
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/key_reg_arbiter.sv
// Round-robin arbiter owning the write port of a shared key/config holding register.
module key_reg_arbiter
    import key_arb_pkg::*;
#(
    parameter  int N_REQ    = N_REQ_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    localparam int ID_W     = width_of(N_REQ),
    localparam int HOLD_W   = width_of(MAX_HOLD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        wr_en,
    input  logic [N_REQ*DATA_W-1:0] wr_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    gnt_vld,
    output logic [ID_W-1:0]         gnt_id,
    output logic [DATA_W-1:0]       q,
    output logic [DATA_W-1:0]       qb,
    output logic                    timeout
);

    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [N_REQ-1:0]  GNT_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_e          state_r, state_nxt_s;
    logic [N_REQ-1:0]    gnt_r, gnt_nxt_s;
    logic                gnt_vld_r;
    logic [ID_W-1:0]     gnt_id_r, gnt_id_nxt_s;
    logic [ID_W-1:0]     ptr_r, ptr_nxt_s, ptr_after_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_nxt_s;
    logic [DATA_W-1:0]   q_r, q_nxt_s;
    logic                timeout_r, timeout_nxt_s;
    logic                pick_found_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic                wr_hit_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign ptr_after_s = (gnt_id_r == ID_LAST) ? '0 : (gnt_id_r + ID_W'(1));

    // Arbitration FSM: IDLE always lasts one cycle, so a release can never regrant on the same edge
    always_comb begin
        state_nxt_s    = state_r;
        gnt_nxt_s      = gnt_r;
        gnt_id_nxt_s   = gnt_id_r;
        hold_cnt_nxt_s = hold_cnt_r;
        ptr_nxt_s      = ptr_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s    = ST_GRANT;
                    gnt_nxt_s      = GNT_ONE << pick_idx_s;
                    gnt_id_nxt_s   = pick_idx_s;
                    hold_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id_r]) begin
                    state_nxt_s    = ST_IDLE;
                    gnt_nxt_s      = '0;
                    gnt_id_nxt_s   = '0;
                    hold_cnt_nxt_s = '0;
                    ptr_nxt_s      = ptr_after_s;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s    = ST_IDLE;
                    gnt_nxt_s      = '0;
                    gnt_id_nxt_s   = '0;
                    hold_cnt_nxt_s = '0;
                    ptr_nxt_s      = ptr_after_s;
                    timeout_nxt_s  = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                gnt_nxt_s      = '0;
                gnt_id_nxt_s   = '0;
                hold_cnt_nxt_s = '0;
            end
        endcase
    end

    // Write mux: only the current grant holder may load, including on its releasing edge
    always_comb begin
        wr_hit_s = (state_r == ST_GRANT) && wr_en[gnt_id_r];
        if (wr_hit_s) begin
            q_nxt_s = wr_data[gnt_id_r*DATA_W +: DATA_W];
        end else begin
            q_nxt_s = q_r;
        end
    end

    // State, grant, pointer and shared register; reset drops any grant at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            gnt_r      <= '0;
            gnt_vld_r  <= 1'b0;
            gnt_id_r   <= '0;
            ptr_r      <= '0;
            hold_cnt_r <= '0;
            q_r        <= '0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            gnt_vld_r  <= |gnt_nxt_s;
            gnt_id_r   <= gnt_id_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            q_r        <= q_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_vld = gnt_vld_r;
    assign gnt_id  = gnt_id_r;
    assign q       = q_r;
    assign qb      = ~q_r;
    assign timeout = timeout_r;

endmodule
